// File: rtl/byte_pack_arbiter.sv
// Round-robin arbiter feeding one byte-to-word packer; one requester owns the packer for a whole word.
// 6 cycles per 4-byte word; the grant is held while the owner stalls, and the word holds while word_ready is low.
module byte_pack_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req0_data,
    input  logic             req0_valid,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic [7:0]       req1_data,
    input  logic             req1_valid,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic [31:0]      word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_src,
    output logic [2:0]       word_bytes,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {IDLE, PACK, OUT} state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             rr_q, rr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [31:0]      shift_q, shift_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;

    assign sel_valid = gnt_q ? req1_valid : req0_valid;
    assign sel_last  = gnt_q ? req1_last  : req0_last;
    assign sel_data  = gnt_q ? req1_data  : req0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= 3'd0;
            shift_q <= 32'd0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = PACK;
                    cnt_d   = 3'd0;
                    shift_d = 32'd0;
                    // rr only matters on a tie; a lone requester always wins
                    gnt_d   = (req0_valid && req1_valid) ? rr_q : req1_valid;
                end
            end
            PACK: begin
                if (sel_valid) begin
                    shift_d = {shift_q[23:0], sel_data};
                    cnt_d   = cnt_q + 3'd1;
                    if (sel_last || cnt_q == 3'd3) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (word_ready) begin
                    wcnt_d  = wcnt_q + CNT_W'(1);
                    rr_d    = ~gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = (state_q == PACK) && !gnt_q;
    assign req1_ready = (state_q == PACK) &&  gnt_q;
    assign word_valid = (state_q == OUT);
    assign word_src   = gnt_q;
    assign word_bytes = (state_q == OUT) ? cnt_q : 3'd0;
    assign word_count = wcnt_q;

    // Left-justify: first byte lands in [31:24], unused low bytes are zero
    always_comb begin
        word_out = 32'd0;
        if (state_q == OUT) begin
            case (cnt_q)
                3'd1:    word_out = {shift_q[7:0],  24'd0};
                3'd2:    word_out = {shift_q[15:0], 16'd0};
                3'd3:    word_out = {shift_q[23:0], 8'd0};
                3'd4:    word_out = shift_q;
                default: word_out = 32'd0;
            endcase
        end
    end

endmodule
